mat_c_writeback: RTL and testbench



---
 rtl/mat_c_writeback_pkg.sv | 27 ++
 rtl/mat_c_writeback_sync_fifo.sv | 42 ++++
 rtl/mat_c_writeback.sv | 141 ++++++++++++++
 tb/tb_mat_c_writeback.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_c_writeback_pkg.sv
// Shared constants, helpers and state encoding for the matrix C writeback stage.
package mat_c_writeback_pkg;

    localparam int DEF_WIDTH          = 16;
    localparam int DEF_BLOCK_SIZE     = 2;
    localparam int DEF_CHUNK_SIZE     = DEF_BLOCK_SIZE * DEF_BLOCK_SIZE;
    localparam int DEF_ROW_SIZE_MAT_A = 16;
    localparam int DEF_COL_SIZE_MAT_B = 10;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_ADDR_WIDTH     = 6;

    localparam int COL_SIZE_MAT_C = DEF_COL_SIZE_MAT_B / DEF_BLOCK_SIZE;
    localparam int ROW_SIZE_MAT_C = DEF_ROW_SIZE_MAT_A / DEF_BLOCK_SIZE;
    localparam int TOTAL_BLOCKS   = COL_SIZE_MAT_C * ROW_SIZE_MAT_C;

    // Smallest address width able to index n blocks (at least one bit).
    function automatic int addr_width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mat_c_writeback_sync_fifo.sv
// Single-clock show-ahead FIFO; push and pop may coincide, including when full.
module mat_c_writeback_sync_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign rd_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_c_writeback.sv
// Captures finished C blocks, buffers them and writes them to C memory in raster order.
module mat_c_writeback
    import mat_c_writeback_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
    parameter int CHUNK_SIZE     = DEF_CHUNK_SIZE,
    parameter int ROW_SIZE_MAT_A = DEF_ROW_SIZE_MAT_A,
    parameter int COL_SIZE_MAT_B = DEF_COL_SIZE_MAT_B,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [WIDTH*CHUNK_SIZE-1:0] in_data,
    input  logic                        mem_ready,
    output logic                        mem_wr_en,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [WIDTH*CHUNK_SIZE-1:0] mem_wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [ADDR_WIDTH:0]         blocks_written
);

    localparam int DW    = WIDTH * CHUNK_SIZE;
    localparam int COL_C = COL_SIZE_MAT_B / BLOCK_SIZE;
    localparam int ROW_C = ROW_SIZE_MAT_A / BLOCK_SIZE;
    localparam int TOTAL = ROW_C * COL_C;

    localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH+1)'(TOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(COL_C - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_C_W  = ADDR_WIDTH'(COL_C);

    wb_state_t             state;
    logic [ADDR_WIDTH-1:0] row_blk;
    logic [ADDR_WIDTH-1:0] col_blk;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;

    logic run;
    logic wr_done;
    logic last_wr;
    logic load;
    logic bypass;
    logic drop;

    assign run     = (state == ST_RUN);
    assign wr_done = mem_wr_en && mem_ready;
    assign last_wr = wr_done && (blocks_written == LAST_CNT);
    // The output register refills whenever it is empty or its write is completing,
    // except on the final write, which leaves the port idle.
    assign load    = run && (!mem_wr_en || wr_done) && !last_wr;
    assign fifo_pop  = load && !fifo_empty;
    // An empty FIFO lets a new block go straight to the output register.
    assign bypass    = load && fifo_empty && in_valid;
    assign fifo_push = run && in_valid && !bypass && (!fifo_full || fifo_pop);
    assign drop      = run && in_valid && !bypass && fifo_full && !fifo_pop;

    assign mem_addr = row_blk * COL_C_W + col_blk;
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    mat_c_writeback_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            row_blk        <= '0;
            col_blk        <= '0;
            blocks_written <= '0;
            overflow       <= 1'b0;
            mem_wr_en      <= 1'b0;
            mem_wr_data    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_RUN;
                        row_blk        <= '0;
                        col_blk        <= '0;
                        blocks_written <= '0;
                        overflow       <= 1'b0;
                    end else if (state == ST_DONE && in_valid) begin
                        overflow <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wr_done) begin
                        blocks_written <= blocks_written + 1'b1;
                        if (col_blk == COL_LAST) begin
                            col_blk <= '0;
                            row_blk <= row_blk + 1'b1;
                        end else begin
                            col_blk <= col_blk + 1'b1;
                        end
                        if (last_wr) begin
                            state <= ST_DONE;
                        end
                    end
                    if (last_wr) begin
                        mem_wr_en <= 1'b0;
                    end else if (load) begin
                        if (!fifo_empty) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= fifo_head;
                        end else if (in_valid) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= in_data;
                        end else begin
                            mem_wr_en <= 1'b0;
                        end
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_c_writeback.sv
// Randomized scoreboard bench for mat_c_writeback against a block-occupancy reference model.
module tb_mat_c_writeback;
  import mat_c_writeback_pkg::*;

  localparam int DW    = DEF_WIDTH * DEF_CHUNK_SIZE;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DEPTH = DEF_FIFO_DEPTH;
  localparam int TOTAL = TOTAL_BLOCKS;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          mem_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   blocks_written;

  mat_c_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .mem_ready      (mem_ready),
    .mem_wr_en      (mem_wr_en),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .blocks_written (blocks_written)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the blocks held inside the stage (output register plus
  // buffer, capacity DEPTH+1); a held block is written whenever mem_ready is high.
  logic [AW+DW-1:0] exp_q[$];
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int m_held = 0;
  int m_written = 0;
  int m_acc = 0;
  bit m_ovf = 1'b0;
  int m_c;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_held = 0; m_written = 0; m_acc = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      case (m_state)
        1: begin
          m_c = (m_held > 0 && mem_ready) ? 1 : 0;
          if (in_valid) begin
            if (m_held - m_c < DEPTH + 1) begin
              exp_q.push_back({AW'(m_acc), in_data});
              m_acc++;
              m_held++;
            end else begin
              m_ovf = 1'b1;
            end
          end
          m_held    -= m_c;
          m_written += m_c;
          if (m_written == TOTAL) m_state = 2;
        end
        default: begin
          if (start) begin
            m_state = 1; m_written = 0; m_acc = 0; m_ovf = 1'b0;
          end else if (m_state == 2 && in_valid) begin
            m_ovf = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic [AW+DW-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("wr_en", mem_wr_en, (m_state == 1 && m_held > 0));
      check("busy", busy, (m_state == 1));
      check("done", done, (m_state == 2));
      check("overflow", overflow, m_ovf);
      check("blocks_written", blocks_written, m_written);
      if (prev_stall) begin
        check("hold_en", mem_wr_en, 1'b1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_data", mem_wr_data, prev_data);
      end
      if (mem_wr_en && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e[AW+DW-1:DW]);
          check("wr_data", mem_wr_data, e[DW-1:0]);
        end
      end
      prev_stall = mem_wr_en && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wr_data;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_wr_en"}, mem_wr_en, 1'b0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, mem_wr_data, 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_blocks"}, blocks_written, 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // in_valid while idle is ignored
    send(rnd());
    repeat (3) tick();
    @(negedge clk);
    check("idle_no_write", mem_wr_en, 1'b0);
    check("idle_no_overflow", overflow, 1'b0);

    // Nominal run: data = index so address k carries data k
    pulse_start();
    for (int k = 0; k < TOTAL; k++) begin
      send(DW'(k));
      repeat (3) tick();
    end
    wait_done(200);
    @(negedge clk);
    check("run1_blocks", blocks_written, TOTAL);
    check("run1_overflow", overflow, 1'b0);

    // in_valid in DONE flags overflow, start clears everything
    send(rnd());
    @(negedge clk);
    check("done_in_valid_ovf", overflow, 1'b1);
    check("done_still_done", done, 1'b1);
    pulse_start();
    @(negedge clk);
    check("restart_busy", busy, 1'b1);
    check("restart_done", done, 1'b0);
    check("restart_ovf", overflow, 1'b0);
    check("restart_blocks", blocks_written, 0);
    check("restart_addr", mem_addr, 0);

    // Backpressure: first write held stable, no loss
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(rnd());
      tick();
    end
    repeat (10) tick();
    mem_ready = 1'b1;
    repeat (5) tick();

    // Full FIFO plus pop in the same cycle: push accepted
    mem_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) send(rnd());
    repeat (2) tick();
    @(negedge clk);
    check("full_no_ovf", overflow, 1'b0);
    mem_ready = 1'b1;
    send(rnd());
    @(negedge clk);
    check("full_pop_no_ovf", overflow, 1'b0);
    repeat (10) tick();

    // Overflow: one block in the output register plus DEPTH buffered, next drops
    mem_ready = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) send(rnd());
    @(negedge clk);
    check("fill_no_ovf", overflow, 1'b0);
    send(rnd());
    @(negedge clk);
    check("drop_ovf", overflow, 1'b1);
    mem_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("ovf_sticky", overflow, 1'b1);

    // Random traffic to finish the matrix
    for (int g = 0; g < 3000 && m_acc < TOTAL; g++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = rnd();
      mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    wait_done(200);
    @(negedge clk);
    check("run2_blocks", blocks_written, TOTAL);

    // Reset mid-run after 17 writes
    pulse_start();
    for (int i = 0; i < 200 && blocks_written != 17; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    check("reached_17", blocks_written, 17);
    rst = 1'b1;
    tick();
    check_all_zero("midrun_reset");
    rst = 1'b0;
    tick();
    pulse_start();
    send(rnd());
    repeat (4) tick();
    @(negedge clk);
    check("post_reset_blocks", blocks_written, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
